pipeline_hazard_ctrl: RTL

//   Sequences the 5-stage pipeline registers (PC, F/D, D/E, E/M, M/W): generates enables/flushes
//   for load-use bubbles, branch mispredict redirects, I-cache and D-cache miss stalls.

---
 rtl/pipeline_hazard_ctrl_if.sv | 57 +++++
 rtl/pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of datapath hazard events and the pipeline-register controls for pipeline_hazard_ctrl.
// Optional perf counters appear when PIPE_CTRL_PERF_EN is defined.
interface pipeline_hazard_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
`ifdef PIPE_CTRL_PERF_EN
  , parameter int PERF_WIDTH   = 32
`endif
);
  logic [REG_ADDR_WIDTH-1:0] D_rs1;
  logic [REG_ADDR_WIDTH-1:0] D_rs2;
  logic [REG_ADDR_WIDTH-1:0] E_rd;
  logic                      E_mem_read;
  logic                      E_mispredict;
  logic [DATA_WIDTH-1:0]     E_target;
  logic                      icache_miss;
  logic                      icache_ready;
  logic                      dcache_miss;
  logic                      dcache_ready;
  logic                      F_pc_en;
  logic                      F_pc_sel;
  logic [DATA_WIDTH-1:0]     redirect_pc;
  logic                      F_D_en;
  logic                      CTRL_Flush;
  logic                      D_E_en;
  logic                      D_E_flush;
  logic                      E_M_en;
  logic                      M_W_en;
`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_WIDTH-1:0]     perf_stall_cycles;
  logic [PERF_WIDTH-1:0]     perf_flushes;
`endif

  // Events are level/pulse signals sampled every rising edge; there is no valid/ready
  // handshake: the controller answers combinationally in the same cycle.
  // master: datapath/cache side (raises events, consumes controls)
  modport master (
    output D_rs1, D_rs2, E_rd, E_mem_read, E_mispredict, E_target,
    output icache_miss, icache_ready, dcache_miss, dcache_ready,
    input  F_pc_en, F_pc_sel, redirect_pc, F_D_en, CTRL_Flush,
    input  D_E_en, D_E_flush, E_M_en, M_W_en
`ifdef PIPE_CTRL_PERF_EN
    , input perf_stall_cycles, perf_flushes
`endif
  );

  // slave: the hazard controller
  modport slave (
    input  D_rs1, D_rs2, E_rd, E_mem_read, E_mispredict, E_target,
    input  icache_miss, icache_ready, dcache_miss, dcache_ready,
    output F_pc_en, F_pc_sel, redirect_pc, F_D_en, CTRL_Flush,
    output D_E_en, D_E_flush, E_M_en, M_W_en
`ifdef PIPE_CTRL_PERF_EN
    , output perf_stall_cycles, perf_flushes
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use bubbles, mispredict redirects, I/D-cache miss stalls.
// Define PIPE_CTRL_PERF_EN to add stall-cycle and redirect-flush counters.
module pipeline_hazard_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
`ifdef PIPE_CTRL_PERF_EN
  , parameter int PERF_WIDTH   = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave bus,
  output logic [1:0]           state_dbg
);
  typedef enum logic [1:0] {RUN = 2'd0, IMISS = 2'd1, DMISS = 2'd2} state_e;

  state_e                state_q, state_d;
  state_e                ret_q, ret_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] redir_q, redir_d;
  logic                  idone_q, idone_d;

  logic                  load_use;
  logic                  pc_en, pc_sel, fd_en, fd_flush, de_en, de_flush, em_en, mw_en;
  logic [DATA_WIDTH-1:0] rpc;

  assign load_use = bus.E_mem_read && (bus.E_rd != '0) &&
                    ((bus.E_rd == bus.D_rs1) || (bus.E_rd == bus.D_rs2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      pend_q  <= 1'b0;
      redir_q <= '0;
      idone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      pend_q  <= pend_d;
      redir_q <= redir_d;
      idone_q <= idone_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    pend_d   = pend_q;
    redir_d  = redir_q;
    idone_d  = idone_q;
    pc_en    = 1'b1;
    pc_sel   = 1'b0;
    rpc      = pend_q ? redir_q : '0;
    fd_en    = 1'b1;
    fd_flush = 1'b0;
    de_en    = 1'b1;
    de_flush = 1'b0;
    em_en    = 1'b1;
    mw_en    = 1'b1;

    case (state_q)
      RUN: begin
        if (bus.dcache_miss) begin
          {pc_en, fd_en, de_en, em_en, mw_en} = '0;
          ret_d   = RUN;
          state_d = DMISS;
        end else if (bus.E_mispredict) begin
          // Wrong-path fetch and load-use in D are irrelevant once E redirects.
          pc_sel   = 1'b1;
          rpc      = bus.E_target;
          fd_flush = 1'b1;
          de_flush = 1'b1;
        end else if (load_use) begin
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          de_flush = 1'b1;
          if (bus.icache_miss) state_d = IMISS;
        end else if (bus.icache_miss) begin
          pc_en    = 1'b0;
          fd_flush = 1'b1;
          state_d  = IMISS;
        end
      end

      IMISS: begin
        if (bus.dcache_miss) begin
          {pc_en, fd_en, de_en, em_en, mw_en} = '0;
          ret_d   = IMISS;
          if (bus.icache_ready) idone_d = 1'b1;
          state_d = DMISS;
        end else begin
          pc_en    = 1'b0;
          fd_flush = 1'b1;
          if (bus.E_mispredict) begin
            de_flush = 1'b1;
            redir_d  = bus.E_target;
            pend_d   = 1'b1;
          end
          if (bus.icache_ready || idone_q) begin
            pc_en   = 1'b1;
            idone_d = 1'b0;
            state_d = RUN;
            if (pend_q || bus.E_mispredict) begin
              // The returned line is on the wrong path: drop it and redirect instead.
              pc_sel = 1'b1;
              rpc    = bus.E_mispredict ? bus.E_target : redir_q;
              pend_d = 1'b0;
            end else begin
              fd_flush = 1'b0;
            end
          end
        end
      end

      DMISS: begin
        {pc_en, fd_en, de_en, em_en, mw_en} = '0;
        if (bus.icache_ready && (ret_q == IMISS)) idone_d = 1'b1;
        if (bus.dcache_ready) state_d = ret_q;
      end

      default: state_d = RUN;
    endcase

    if (rst) begin
      {pc_en, fd_en, de_en, em_en, mw_en} = '0;
      pc_sel   = 1'b0;
      rpc      = '0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end
  end

  assign bus.F_pc_en     = pc_en;
  assign bus.F_pc_sel    = pc_sel;
  assign bus.redirect_pc = rpc;
  assign bus.F_D_en      = fd_en;
  assign bus.CTRL_Flush  = fd_flush;
  assign bus.D_E_en      = de_en;
  assign bus.D_E_flush   = de_flush;
  assign bus.E_M_en      = em_en;
  assign bus.M_W_en      = mw_en;
  assign state_dbg       = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_WIDTH-1:0] stall_q, flush_q;

  // A redirect is the only case where the PC selects redirect_pc while F/D is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en)             stall_q <= stall_q + 1'b1;
      if (pc_sel && fd_flush) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.perf_stall_cycles = stall_q;
  assign bus.perf_flushes      = flush_q;
`endif
endmodule
